// File: rtl/switch_pkg.sv
// Shared types and elaboration helpers for the switch egress path.
package switch_pkg;

  typedef longint port_speed_t;
  typedef logic [31:0] beat_count_t;

  localparam int unsigned PACER_CALC_W = 128;
  typedef logic [PACER_CALC_W-1:0] pacer_wide_t;

  // Credit cost of one beat: clock frequency times bits per beat.
  function automatic pacer_wide_t pacer_cost(input pacer_wide_t freq, input pacer_wide_t len);
    return freq * len;
  endfunction

endpackage

// File: rtl/switch_pacer_lane.sv
// One egress port: token-bucket accumulator, ready generation and the
// registered accepted-beat stage.
module switch_pacer_lane
  import switch_pkg::*;
#(
  parameter int unsigned                ACC_WIDTH  = 96,
  parameter int unsigned                DATA_WIDTH = 8,
  parameter logic [ACC_WIDTH-1:0]       COST       = '1,
  parameter logic [ACC_WIDTH-1:0]       CAP        = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  port_speed_t           speed,
  input  logic                  enable,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output beat_count_t           count
);

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  add, sum;
  logic                  en_q, en_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  beat_count_t           cnt_q, cnt_d;
  logic                  fire;

  always_comb begin
    ready   = en_q && (acc_q >= COST);
    fire    = valid && ready;
    add     = (speed > 0) ? ACC_WIDTH'(unsigned'(speed)) : '0;
    // fire implies acc_q >= COST, so the debit never underflows
    sum     = acc_q + add - (fire ? COST : '0);
    acc_d   = !enable ? '0 : ((sum > CAP) ? CAP : sum);
    en_d    = enable;
    valid_d = fire;
    data_d  = fire ? data : data_q;
    cnt_d   = fire ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign count     = cnt_q;

endmodule

// File: rtl/switch_port_pacer.sv
// Per-port transmit rate limiter: throttles o_txReady so each port's
// sustained throughput tracks i_portSpeed, with bursts bounded by the bucket.
module switch_port_pacer
  import switch_pkg::*;
#(
  parameter int     g_DEVICES       = 2,
  parameter longint g_FREQUENCY     = 125000000,
  parameter int     g_AVALON_LENGTH = 8,
  parameter int     g_BURST_BEATS   = 4,
  parameter int     g_ACC_WIDTH     = 96
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  port_speed_t                          i_portSpeed [g_DEVICES-1:0],
  input  logic [g_DEVICES-1:0]                 i_portEnable,
  input  logic [g_DEVICES-1:0]                 i_valid,
  output logic                                 o_txReady [g_DEVICES-1:0],
  input  logic [g_AVALON_LENGTH*g_DEVICES-1:0] i_avalonVec,
  output logic [g_AVALON_LENGTH*g_DEVICES-1:0] o_avalonVec,
  output logic [g_DEVICES-1:0]                 o_valid,
  output beat_count_t                          o_beatCount [g_DEVICES-1:0]
);

  localparam pacer_wide_t COST_W =
    pacer_cost(pacer_wide_t'(g_FREQUENCY), pacer_wide_t'(g_AVALON_LENGTH));
  localparam pacer_wide_t CAP_W    = COST_W * pacer_wide_t'(g_BURST_BEATS);
  localparam pacer_wide_t HEADROOM = CAP_W + (pacer_wide_t'(1) << 63);

  localparam logic [g_ACC_WIDTH-1:0] COST = g_ACC_WIDTH'(COST_W);
  localparam logic [g_ACC_WIDTH-1:0] CAP  = g_ACC_WIDTH'(CAP_W);

  // Accumulator must hold CAP plus the largest possible per-cycle credit.
  if (g_ACC_WIDTH < 64 ||
      (g_ACC_WIDTH < int'(PACER_CALC_W) && (HEADROOM >> g_ACC_WIDTH) != '0)) begin : g_acc_width_check
    $error("switch_port_pacer: g_ACC_WIDTH too small for CAP + 2^63");
  end
  if (g_DEVICES < 1 || g_BURST_BEATS < 1) begin : g_param_check
    $error("switch_port_pacer: g_DEVICES and g_BURST_BEATS must be >= 1");
  end

  for (genvar p = 0; p < g_DEVICES; p++) begin : g_lane
    switch_pacer_lane #(
      .ACC_WIDTH  (g_ACC_WIDTH),
      .DATA_WIDTH (g_AVALON_LENGTH),
      .COST       (COST),
      .CAP        (CAP)
    ) u_lane (
      .clk       (i_clk),
      .reset_n   (i_reset_n),
      .speed     (i_portSpeed[p]),
      .enable    (i_portEnable[p]),
      .valid     (i_valid[p]),
      .data      (i_avalonVec[p*g_AVALON_LENGTH +: g_AVALON_LENGTH]),
      .ready     (o_txReady[p]),
      .out_valid (o_valid[p]),
      .out_data  (o_avalonVec[p*g_AVALON_LENGTH +: g_AVALON_LENGTH]),
      .count     (o_beatCount[p])
    );
  end

endmodule

// File: tb/tb_switch_port_pacer.sv
// Directed bench for switch_port_pacer with COST=800, CAP=3200.
module tb_switch_port_pacer;

  logic        clk = 1'b0;
  logic        rst_n;
  longint      speed [1:0];
  logic [1:0]  en;
  logic [1:0]  vld;
  logic [15:0] din;
  logic        rdy [1:0];
  logic [15:0] dout;
  logic [1:0]  ovld;
  logic [31:0] cnt [1:0];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  switch_port_pacer #(
    .g_DEVICES       (2),
    .g_FREQUENCY     (100),
    .g_AVALON_LENGTH (8),
    .g_BURST_BEATS   (4),
    .g_ACC_WIDTH     (96)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_portSpeed  (speed),
    .i_portEnable (en),
    .i_valid      (vld),
    .o_txReady    (rdy),
    .i_avalonVec  (din),
    .o_avalonVec  (dout),
    .o_valid      (ovld),
    .o_beatCount  (cnt)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  en;
    logic [15:0] din;
    logic [1:0]  ready;
    logic [1:0]  vld;
    logic [15:0] dout;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got %0h want %0h", name, got, want);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 2'b11;
    vld   = 2'b11;
    din   = '0;
    speed[0] = 400;
    speed[1] = 800;

    // Port0 at 400, port1 at 800; port0 disabled mid-stream, then reset mid-burst.
    vecs[0]  = '{1'b0, 2'b11, 16'hB0A0, 2'b00, 2'b00, 16'h0000, 32'd0, 32'd0};
    vecs[1]  = '{1'b1, 2'b11, 16'hB1A1, 2'b10, 2'b00, 16'h0000, 32'd0, 32'd0};
    vecs[2]  = '{1'b1, 2'b11, 16'hB2A2, 2'b11, 2'b10, 16'hB200, 32'd0, 32'd1};
    vecs[3]  = '{1'b1, 2'b11, 16'hB3A3, 2'b10, 2'b11, 16'hB3A3, 32'd1, 32'd2};
    vecs[4]  = '{1'b1, 2'b11, 16'hB4A4, 2'b11, 2'b10, 16'hB4A3, 32'd1, 32'd3};
    vecs[5]  = '{1'b1, 2'b10, 16'hB5A5, 2'b10, 2'b11, 16'hB5A5, 32'd2, 32'd4};
    vecs[6]  = '{1'b1, 2'b10, 16'hB6A6, 2'b10, 2'b10, 16'hB6A5, 32'd2, 32'd5};
    vecs[7]  = '{1'b1, 2'b11, 16'hB7A7, 2'b10, 2'b10, 16'hB7A5, 32'd2, 32'd6};
    vecs[8]  = '{1'b1, 2'b11, 16'hB8A8, 2'b11, 2'b10, 16'hB8A5, 32'd2, 32'd7};
    vecs[9]  = '{1'b1, 2'b11, 16'hB9A9, 2'b10, 2'b11, 16'hB9A9, 32'd3, 32'd8};
    vecs[10] = '{1'b0, 2'b11, 16'hBAAA, 2'b00, 2'b00, 16'h0000, 32'd0, 32'd0};
    vecs[11] = '{1'b1, 2'b11, 16'hBBAB, 2'b10, 2'b00, 16'h0000, 32'd0, 32'd0};
    vecs[12] = '{1'b1, 2'b11, 16'hBCAC, 2'b11, 2'b10, 16'hBC00, 32'd0, 32'd1};

    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n;
      en    = vecs[i].en;
      din   = vecs[i].din;
      step();
      check($sformatf("vec%0d_ready", i), 64'({rdy[1], rdy[0]}), 64'(vecs[i].ready));
      check($sformatf("vec%0d_valid", i), 64'(ovld), 64'(vecs[i].vld));
      check($sformatf("vec%0d_data", i), 64'(dout), 64'(vecs[i].dout));
      check($sformatf("vec%0d_cnt0", i), 64'(cnt[0]), 64'(vecs[i].c0));
      check($sformatf("vec%0d_cnt1", i), 64'(cnt[1]), 64'(vecs[i].c1));
    end

    // Speed 400 from reset release: ready after even edges, fires alternate; port1 at -5 never ready.
    en = 2'b11;
    vld = 2'b11;
    speed[0] = 400;
    speed[1] = -5;
    reset_dut();
    for (int k = 1; k <= 22; k++) begin
      din = 16'($urandom);
      step();
      check($sformatf("half_rate_ready_k%0d", k), 64'(rdy[0]), 64'((k % 2) == 0));
      check($sformatf("half_rate_valid_k%0d", k), 64'(ovld[0]), 64'(k >= 3 && (k % 2) == 1));
      check($sformatf("neg_speed_ready_k%0d", k), 64'(rdy[1]), 64'(0));
    end
    check("half_rate_cnt0", 64'(cnt[0]), 64'd10);
    check("neg_speed_cnt1", 64'(cnt[1]), 64'd0);

    // Speed 800 on port0: ready every cycle, data delayed by one; speed 0 on port1 for 50 cycles.
    speed[0] = 800;
    speed[1] = 0;
    reset_dut();
    for (int k = 1; k <= 50; k++) begin
      din = 16'($urandom);
      step();
      check($sformatf("full_rate_ready_k%0d", k), 64'(rdy[0]), 64'(1));
      check($sformatf("zero_speed_ready_k%0d", k), 64'(rdy[1]), 64'(0));
      if (k >= 2) begin
        check($sformatf("full_rate_valid_k%0d", k), 64'(ovld[0]), 64'(1));
        check($sformatf("full_rate_data_k%0d", k), 64'(dout[7:0]), 64'(din[7:0]));
      end else begin
        check("full_rate_valid_first", 64'(ovld[0]), 64'(0));
      end
    end
    check("full_rate_cnt0", 64'(cnt[0]), 64'd49);
    check("zero_speed_cnt1", 64'(cnt[1]), 64'd0);

    // Saturated bucket: 7 back-to-back fires, then alternating.
    speed[0] = 400;
    speed[1] = -5;
    vld = 2'b00;
    reset_dut();
    for (int k = 0; k < 20; k++) step();
    vld = 2'b11;
    for (int j = 1; j <= 12; j++) begin
      din = 16'($urandom);
      step();
      check($sformatf("burst_valid_j%0d", j), 64'(ovld[0]),
            64'((j <= 7) ? 1 : (((j - 7) % 2) == 0)));
    end
    check("burst_cnt0", 64'(cnt[0]), 64'd9);
    check("burst_cnt1", 64'(cnt[1]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
